// File: rtl/riscv_pkg.sv
// Shared RISC-V base definitions used by the fetch stage and its PC register.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // Canonical bubble: addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Fetch control states; HALT is entered on an all-zero instruction word.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    // Instructions are word aligned; drop the two low address bits.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter register with load / increment / hold controls.
// Priority: reset > load > increment > hold. Increment wraps modulo 2^XLEN.
module pc_register
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_pc,
    input  logic            i_incr,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;

    // PC state update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= align_pc(i_load_pc);
        end else if (i_incr) begin
            r_pc <= r_pc + 64'd4;
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, branch redirect, stall hold,
// halt on an all-zero word, IF/ID pipeline register and fetch counter.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [ILEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            halted,
    output logic [XLEN-1:0] fetch_count
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] w_pc;
    logic            w_pc_load;
    logic            w_pc_incr;
    logic [XLEN-1:0] r_if_id_pc;
    logic [ILEN-1:0] r_if_id_instr;
    logic            r_if_id_valid;
    logic [XLEN-1:0] w_if_id_pc_nxt;
    logic [ILEN-1:0] w_if_id_instr_nxt;
    logic            w_if_id_valid_nxt;
    logic            w_cnt_inc;
    logic [XLEN-1:0] r_fetch_count;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_pc_load),
        .i_load_pc (branch_target),
        .i_incr    (w_pc_incr),
        .o_pc      (w_pc)
    );

    // Next-state, PC control and IF/ID next-value decode; branch beats stall beats halt.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_load         = 1'b0;
        w_pc_incr         = 1'b0;
        w_if_id_pc_nxt    = r_if_id_pc;
        w_if_id_instr_nxt = r_if_id_instr;
        w_if_id_valid_nxt = r_if_id_valid;
        w_cnt_inc         = 1'b0;
        if (branch_taken) begin
            // Redirect also pulls fetch out of HALT; the word at the old PC is squashed.
            w_state_nxt       = ST_RUN;
            w_pc_load         = 1'b1;
            w_if_id_pc_nxt    = 64'h0;
            w_if_id_instr_nxt = NOP_INSTR;
            w_if_id_valid_nxt = 1'b0;
        end else if (stall) begin
            // Everything holds.
            w_state_nxt = r_state;
        end else begin
            case (r_state)
                ST_HALT: begin
                    w_if_id_pc_nxt    = 64'h0;
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                end
                ST_RUN: begin
                    if (imem_rdata == 32'h0) begin
                        // Terminating word: never forwarded, PC parks on it.
                        w_state_nxt       = ST_HALT;
                        w_if_id_pc_nxt    = 64'h0;
                        w_if_id_instr_nxt = NOP_INSTR;
                        w_if_id_valid_nxt = 1'b0;
                    end else begin
                        w_pc_incr         = 1'b1;
                        w_if_id_pc_nxt    = w_pc;
                        w_if_id_instr_nxt = imem_rdata;
                        w_if_id_valid_nxt = 1'b1;
                        w_cnt_inc         = 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to RUN with a bubble.
                    w_state_nxt       = ST_RUN;
                    w_if_id_pc_nxt    = 64'h0;
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_if_id_pc    <= 64'h0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else begin
            r_if_id_pc    <= w_if_id_pc_nxt;
            r_if_id_instr <= w_if_id_instr_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
        end
    end

    // Count of valid instructions written into IF/ID, wraps modulo 2^64.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_count <= 64'h0;
        end else if (w_cnt_inc) begin
            r_fetch_count <= r_fetch_count + 64'd1;
        end else begin
            r_fetch_count <= r_fetch_count;
        end
    end

    assign imem_addr   = w_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;
    assign halted      = (r_state == ST_HALT);
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: default-parameter instance for the
// main scenarios, plus a second instance with a wrap-around reset PC.
module tb_fetch_stage;

    localparam logic [63:0] HI_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk;
    logic        rst_n, stall, branch_taken;
    logic [63:0] branch_target;
    logic [63:0] imem_addr, if_id_pc, fetch_count;
    logic [31:0] imem_rdata, if_id_instr;
    logic        if_id_valid, halted;

    logic        rst2_n;
    logic [63:0] imem_addr2, if_id_pc2, fetch_count2;
    logic [31:0] imem_rdata2, if_id_instr2;
    logic        if_id_valid2, halted2;

    logic        zero_en;
    logic [63:0] zero_addr;

    int checks = 0;
    int errors = 0;
    fetch_t sb_q[$];
    fetch_t e;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(HI_PC)) dut2 (
        .clk(clk), .rst_n(rst2_n), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(64'h0), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .if_id_pc(if_id_pc2), .if_id_instr(if_id_instr2), .if_id_valid(if_id_valid2),
        .halted(halted2), .fetch_count(fetch_count2)
    );

    // Memory image: fixed program at 0/4, an optional zero word, else a nonzero address tag.
    function automatic logic [31:0] word_at(input logic [63:0] a, input logic ze, input logic [63:0] za);
        if (ze && a == za) return 32'h0;
        if (a == 64'h0)    return 32'h0050_0093;
        if (a == 64'h4)    return 32'h00a0_0113;
        return {a[31:2], 2'b11};
    endfunction

    always_comb imem_rdata  = word_at(imem_addr,  zero_en, zero_addr);
    always_comb imem_rdata2 = word_at(imem_addr2, zero_en, zero_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h200;
        tick(); tick();
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", imem_addr, 64'h0); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
        checks++; if (if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", if_id_instr, NOP); end
        checks++; if (if_id_pc !== 64'h0) begin errors++; $display("FAIL reset_ifid_pc: got %h expected 0", if_id_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (fetch_count !== 64'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", fetch_count); end
    endtask

    task automatic test_fetch();
        rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        sb_q.push_back('{64'h0, 32'h0050_0093});
        sb_q.push_back('{64'h4, 32'h00a0_0113});
        repeat (2) begin
            tick();
            e = sb_q.pop_front();
            checks++; if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_instr !== e.instr) begin
                errors++; $display("FAIL fetch_seq: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h", if_id_valid, if_id_pc, if_id_instr, e.pc, e.instr);
            end
        end
        checks++; if (fetch_count !== 64'd2) begin errors++; $display("FAIL fetch_count: got %0d expected 2", fetch_count); end
        checks++; if (imem_addr !== 64'h8) begin errors++; $display("FAIL fetch_addr: got %h expected 8", imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        repeat (3) begin
            tick();
            checks++; if (imem_addr !== 64'h8 || if_id_pc !== 64'h4 || if_id_instr !== 32'h00a0_0113 || if_id_valid !== 1'b1 || fetch_count !== 64'd2) begin
                errors++; $display("FAIL stall_hold: got addr=%h pc=%h i=%h v=%b cnt=%0d expected addr=8 pc=4 i=00a00113 v=1 cnt=2", imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_count);
            end
        end
        stall = 1'b0;
        sb_q.push_back('{64'h8, 32'h0000_000B});
        tick();
        e = sb_q.pop_front();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_instr !== e.instr) begin
            errors++; $display("FAIL stall_resume: got pc=%h i=%h expected pc=%h i=%h", if_id_pc, if_id_instr, e.pc, e.instr);
        end
        checks++; if (fetch_count !== 64'd3) begin errors++; $display("FAIL stall_count: got %0d expected 3", fetch_count); end
    endtask

    task automatic test_branch_stall();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h103;
        tick();
        checks++; if (imem_addr !== 64'h100 || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
            errors++; $display("FAIL branch_bubble: got addr=%h v=%b i=%h expected addr=100 v=0 i=%h", imem_addr, if_id_valid, if_id_instr, NOP);
        end
        stall = 1'b0; branch_taken = 1'b0;
        sb_q.push_back('{64'h100, 32'h0000_0103});
        tick();
        e = sb_q.pop_front();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_instr !== e.instr) begin
            errors++; $display("FAIL branch_target_fetch: got pc=%h i=%h expected pc=%h i=%h", if_id_pc, if_id_instr, e.pc, e.instr);
        end
    endtask

    task automatic test_halt();
        zero_en = 1'b1; zero_addr = 64'h20;
        branch_taken = 1'b1; branch_target = 64'h20;
        tick();
        branch_taken = 1'b0;
        repeat (4) begin
            tick();
            checks++; if (halted !== 1'b1 || imem_addr !== 64'h20 || if_id_valid !== 1'b0 || fetch_count !== 64'd4) begin
                errors++; $display("FAIL halt_hold: got h=%b addr=%h v=%b cnt=%0d expected h=1 addr=20 v=0 cnt=4", halted, imem_addr, if_id_valid, fetch_count);
            end
        end
        branch_taken = 1'b1; branch_target = 64'h40;
        tick();
        checks++; if (halted !== 1'b0 || imem_addr !== 64'h40 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL halt_exit: got h=%b addr=%h v=%b expected h=0 addr=40 v=0", halted, imem_addr, if_id_valid);
        end
        branch_taken = 1'b0;
        sb_q.push_back('{64'h40, 32'h0000_0043});
        tick();
        e = sb_q.pop_front();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_instr !== e.instr || fetch_count !== 64'd5) begin
            errors++; $display("FAIL halt_resume: got pc=%h i=%h cnt=%0d expected pc=%h i=%h cnt=5", if_id_pc, if_id_instr, fetch_count, e.pc, e.instr);
        end
    endtask

    task automatic test_zero_with_branch();
        branch_taken = 1'b1; branch_target = 64'h20;
        tick();
        branch_target = 64'h80;
        tick();
        checks++; if (halted !== 1'b0 || imem_addr !== 64'h80 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL zero_branch: got h=%b addr=%h v=%b expected h=0 addr=80 v=0", halted, imem_addr, if_id_valid);
        end
        branch_taken = 1'b0;
        sb_q.push_back('{64'h80, 32'h0000_0083});
        tick();
        e = sb_q.pop_front();
        checks++; if (halted !== 1'b0 || if_id_pc !== e.pc || if_id_instr !== e.instr || fetch_count !== 64'd6) begin
            errors++; $display("FAIL zero_branch_resume: got h=%b pc=%h i=%h cnt=%0d expected h=0 pc=%h i=%h cnt=6", halted, if_id_pc, if_id_instr, fetch_count, e.pc, e.instr);
        end
        zero_en = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        stall = 1'b1; rst_n = 1'b0;
        tick();
        checks++; if (imem_addr !== 64'h0 || fetch_count !== 64'h0 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got addr=%h cnt=%0d v=%b expected addr=0 cnt=0 v=0", imem_addr, fetch_count, if_id_valid);
        end
        rst_n = 1'b1; stall = 1'b0;
        sb_q.push_back('{64'h0, 32'h0050_0093});
        tick();
        e = sb_q.pop_front();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== e.pc || if_id_instr !== e.instr) begin
            errors++; $display("FAIL reset_first_fetch: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h", if_id_valid, if_id_pc, if_id_instr, e.pc, e.instr);
        end
        stall = 1'b1;
    endtask

    task automatic test_reset_pc_wrap();
        zero_en = 1'b1; zero_addr = 64'h0;
        rst2_n = 1'b1;
        tick();
        checks++; if (imem_addr2 !== 64'h0 || fetch_count2 !== 64'd1 || if_id_pc2 !== HI_PC || if_id_instr2 !== 32'hFFFF_FFFF || if_id_valid2 !== 1'b1) begin
            errors++; $display("FAIL wrap_fetch: got addr=%h cnt=%0d pc=%h i=%h v=%b expected addr=0 cnt=1 pc=%h i=ffffffff v=1", imem_addr2, fetch_count2, if_id_pc2, if_id_instr2, if_id_valid2, HI_PC);
        end
        tick();
        checks++; if (halted2 !== 1'b1 || imem_addr2 !== 64'h0 || fetch_count2 !== 64'd1) begin
            errors++; $display("FAIL wrap_halt: got h=%b addr=%h cnt=%0d expected h=1 addr=0 cnt=1", halted2, imem_addr2, fetch_count2);
        end
        rst2_n = 1'b0;
        tick();
        checks++; if (halted2 !== 1'b0 || imem_addr2 !== HI_PC || fetch_count2 !== 64'h0 || if_id_valid2 !== 1'b0) begin
            errors++; $display("FAIL halt_reset: got h=%b addr=%h cnt=%0d v=%b expected h=0 addr=%h cnt=0 v=0", halted2, imem_addr2, fetch_count2, if_id_valid2, HI_PC);
        end
        rst2_n = 1'b1;
        tick();
        checks++; if (if_id_valid2 !== 1'b1 || if_id_pc2 !== HI_PC) begin
            errors++; $display("FAIL halt_reset_refetch: got v=%b pc=%h expected v=1 pc=%h", if_id_valid2, if_id_pc2, HI_PC);
        end
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 64'h0; zero_en = 1'b0; zero_addr = 64'h0;
        test_reset();
        test_fetch();
        test_stall();
        test_branch_stall();
        test_halt();
        test_zero_with_branch();
        test_reset_mid_stall();
        test_reset_pc_wrap();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), bubble word placed in IF/ID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset; sampled on rising clk only.
REQ-005 stall  input  1  hazard stall from decode; holds PC and IF/ID.
REQ-006 branch_taken  input  1  redirect request from execute.
REQ-007 branch_target  input  64  redirect address, valid when branch_taken=1.
REQ-008 imem_addr  output  64  fetch address, equal to current PC.
REQ-009 imem_rdata  input  32  instruction word at imem_addr, combinational same-cycle read.
REQ-010 if_id_pc  output  64  registered PC of the instruction in IF/ID.
REQ-011 if_id_instr  output  32  registered instruction in IF/ID; feeds decode and immediate generation.
REQ-012 if_id_valid  output  1  IF/ID holds a real instruction, not a bubble.
REQ-013 halted  output  1  fetch has stopped on a terminating word.
REQ-014 fetch_count  output  64  number of valid instructions written into IF/ID.

Function
REQ-015 State machine SHALL have exactly two states: RUN and HALT; halted=1 iff state is HALT.
REQ-016 imem_addr SHALL equal the PC register combinationally.
REQ-017 Per-cycle priority SHALL be reset > branch_taken > stall > HALT > normal fetch.
REQ-018 branch_taken=1: PC <= {branch_target[63:2],2'b00}; IF/ID <= {pc 0, NOP_INSTR, valid 0}; state <= RUN, including exit from HALT; stall ignored that cycle.
REQ-019 stall=1 without branch_taken: PC, IF/ID, state and fetch_count all hold.
REQ-020 HALT without branch_taken or stall: PC holds; IF/ID <= bubble.
REQ-021 RUN, imem_rdata != 0: PC <= PC+4; IF/ID <= {PC, imem_rdata, 1}; fetch_count += 1.
REQ-022 RUN, imem_rdata == 32'h0: state <= HALT; PC holds; IF/ID <= bubble; fetch_count unchanged; the zero word is never forwarded.
REQ-023 Fetch-to-IF/ID latency SHALL be one cycle; branch redirect penalty exactly one bubble.
REQ-024 PC+4 SHALL wrap modulo 2^64; fetch_count SHALL wrap modulo 2^64.
REQ-025 A branch_taken in the same cycle as a fetched zero word SHALL redirect and SHALL NOT enter HALT.

Reset
REQ-026 rst_n=0 at a rising edge: PC <= RESET_PC, IF/ID <= {64'h0, NOP_INSTR, 0}, state <= RUN, fetch_count <= 0, overriding stall and branch_taken.
REQ-027 Reset asserted mid-stall or in HALT SHALL give the same result as REQ-026; the first valid fetch occurs in the first cycle with rst_n=1.

Structure
REQ-028 XLEN=64, ILEN=32 and the NOP_INSTR default value SHALL live in shared package riscv_pkg.
REQ-029 The PC register with load/hold/increment controls SHALL be one sub-module, pc_register; the FSM, IF/ID register and counter SHALL reside in fetch_stage.

Verification
REQ-030 Reset, then memory holds 0x00500093 at address 0 and 0x00a00113 at address 4 -> cycle 1: if_id_pc=0, if_id_instr=0x00500093, valid=1; cycle 2: if_id_pc=4; fetch_count=2.
REQ-031 stall=1 for 3 cycles at PC=8 -> imem_addr stays 8, IF/ID unchanged, fetch_count unchanged; fetch resumes at 8 after release.
REQ-032 branch_taken=1 with target 0x103 while stall=1 -> next cycle PC=0x100, if_id_valid=0; following cycle if_id_pc=0x100, valid=1.
REQ-033 Zero word at 0x20 -> halted=1, PC stays 0x20, if_id_valid=0 every cycle; later branch_taken to 0x40 -> halted=0, fetch resumes at 0x40.
REQ-034 Zero word fetched in the same cycle as branch_taken to 0x80 -> halted stays 0, PC=0x80.
REQ-035 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC with a nonzero word there -> after one fetch PC=0, fetch_count=1; rst_n=0 while in HALT -> PC=RESET_PC, halted=0, fetch_count=0.
